caf_sweep_ctrl: RTL
===================

# caf_sweep_ctrl

Sequencer for the CAF peak search. It steps the frequency-shift stage through `freq_bins` bins. For each bin it launches one correlation pass and accepts the per-bin `arg_max` result over a valid/ready handshake. It keeps a running global peak and presents the final (max, time index, frequency bin) triple to downstream logic over a second valid/ready handshake. It sits between the top-level CAF control and the correlator/`arg_max` datapath.

## Interface
Parameters:
- `freq_bins`, 16: number of frequency bins per sweep; 1 ≤ `freq_bins` ≤ 2^`freq_bits`.
- `freq_bits`, 4: width of the bin number.
- `index_bits`, 4: `arg_max` index parameter; the index bus is `index_bits+1` wide.
- `out_max_bits`, 4: width of the magnitude value.
- `timeout_cycles`, 1024: maximum WAIT cycles per bin before abort; ≥ 1; 32-bit counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request; sampled only in IDLE.
- `freq_bin` out `freq_bits`: current bin, held stable for the whole pass.
- `bin_start` out 1: one-cycle pulse that begins a pass.
- `res_valid` in 1: per-bin result valid (from `arg_max` `s_axis_tvalid`).
- `res_max` in `out_max_bits`: per-bin peak magnitude.
- `res_index` in `index_bits+1`: per-bin peak time index.
- `res_ready` out 1: controller accepts a result.
- `best_max` out `out_max_bits`: global peak magnitude.
- `best_index` out `index_bits+1`: time index of the global peak.
- `best_freq` out `freq_bits`: bin of the global peak.
- `out_valid` out 1: final result valid.
- `out_ready` in 1: downstream accepts the final result.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: the sweep was aborted by timeout; valid while `out_valid` is high.

## Operation
States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: `start`=1 → clear bin to 0, clear `timeout_err`, go to LAUNCH. `start` in any other state is ignored.
- LAUNCH: `bin_start`=1 for exactly one cycle with `freq_bin` = current bin; go to WAIT and clear the wait counter.
- WAIT: `res_ready`=1. The wait counter increments every cycle without `res_valid`.
  - On `res_valid`: the result is accepted this cycle.
    - If it is bin 0, or `res_max` > `best_max` (unsigned, strict), load `best_max`/`best_index`/`best_freq` from `res_max`/`res_index`/`freq_bin`.
    - On ties the earlier bin wins.
    - If bin == `freq_bins`-1 → DONE; otherwise bin+1 → LAUNCH.
  - If the counter reaches `timeout_cycles` without `res_valid` → DONE with `timeout_err`=1. The best registers hold the partial result; if bin 0 timed out they hold their previous values.
- DONE: `out_valid`=1; the outputs hold until `out_ready`=1, then go to IDLE. `start` in the same cycle is ignored and must be re-asserted.
- `res_ready`=0 outside WAIT. `res_valid` outside WAIT is ignored and never updates state.
- The best registers are not cleared at sweep start; bin 0 overwrites them unconditionally.

## Timing
- Reset (async assert, sync release): state IDLE; `freq_bin`, `best_max`, `best_index`, `best_freq` = 0; `bin_start`, `res_ready`, `out_valid`, `busy`, `timeout_err` = 0.
- Reset mid-sweep aborts immediately; there is no `out_valid` for the aborted sweep.
- `start` sampled high at edge k → LAUNCH in cycle k+1 (`bin_start`, `busy` high) → WAIT from k+2.
- Result accepted at edge m → updated best registers visible in cycle m+1; next LAUNCH or DONE also in m+1.
- Minimum per-bin cost is 2 cycles (LAUNCH + 1 WAIT cycle), so a sweep with zero-latency results takes 2·`freq_bins` cycles from LAUNCH to DONE.
- `res_valid` sampled on the first WAIT cycle is accepted; no bubble is required.
- Timeout: `res_valid` absent for `timeout_cycles` consecutive WAIT cycles → DONE on the next cycle. `res_valid` arriving on the same cycle the limit is reached wins, and no timeout is flagged.
- All outputs are registered.

## Test plan
- Nominal sweep, `freq_bins`=4: per-bin results (max, index) = (3,2),(9,5),(7,1),(9,8) → `best_max`=9, `best_index`=5, `best_freq`=1, `timeout_err`=0, exactly 4 `bin_start` pulses with `freq_bin` 0..3.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and the best outputs stay stable; pulse `out_ready` → IDLE next cycle, `busy`=0.
- Timeout, `timeout_cycles`=8: answer bin 0 with (5,3), never answer bin 1 → DONE 9 cycles after bin 1's WAIT begins, `timeout_err`=1, `best_max`=5, `best_freq`=0.
- Ignored inputs: pulse `res_valid` in IDLE and LAUNCH, and `start` during WAIT → no state, bin or best change; the sweep completes normally.
- Async reset asserted mid-WAIT at bin 2 → all outputs at reset values immediately, with no clock edge needed; a fresh `start` restarts at bin 0.
- `freq_bins`=1, result (0,0) → DONE with `best_max`=0, `best_freq`=0: bin 0 loads unconditionally even at zero magnitude.

Source files
------------

// File: rtl/caf_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// caf_sweep_ctrl
//
// Sequencer for the CAF peak search. It walks the frequency-shift stage through
// freq_bins bins. For each bin it launches one correlation pass, then takes the
// per-bin arg_max result over a valid/ready handshake. While doing so it keeps
// a running global peak. The final (magnitude, time index, bin) triple goes to
// downstream logic over a second valid/ready handshake.
//
// Ports
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   start                   : sweep request, only looked at while idle
//   freq_bin, bin_start     : current bin and one-cycle pass launch pulse
//   res_valid/res_ready     : per-bin result handshake
//   res_max, res_index      : per-bin peak magnitude and time index
//   best_max/index/freq     : global peak triple
//   out_valid/out_ready     : final result handshake
//   busy                    : high whenever a sweep is in progress or held
//   timeout_err             : sweep aborted because a bin never answered
// -----------------------------------------------------------------------------
module caf_sweep_ctrl #(
  parameter int freq_bins      = 16,
  parameter int freq_bits      = 4,
  parameter int index_bits     = 4,
  parameter int out_max_bits   = 4,
  parameter int timeout_cycles = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [freq_bits-1:0]    freq_bin,
  output logic                    bin_start,
  input  logic                    res_valid,
  input  logic [out_max_bits-1:0] res_max,
  input  logic [index_bits:0]     res_index,
  output logic                    res_ready,
  output logic [out_max_bits-1:0] best_max,
  output logic [index_bits:0]     best_index,
  output logic [freq_bits-1:0]    best_freq,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [freq_bits-1:0] last_bin    = freq_bits'(freq_bins - 1);
  localparam logic [31:0]          timeout_lim = 32'(timeout_cycles);

  state_t                  state_q, state_d;
  logic [freq_bits-1:0]    bin_q, bin_d;
  logic [31:0]             wait_cnt_q, wait_cnt_d;
  logic [out_max_bits-1:0] best_max_q, best_max_d;
  logic [index_bits:0]     best_index_q, best_index_d;
  logic [freq_bits-1:0]    best_freq_q, best_freq_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    bin_start_q, bin_start_d;
  logic                    res_ready_q, res_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic                    wait_expired;
  logic                    is_last_bin;
  logic                    take_result;

  assign wait_expired = (wait_cnt_q == timeout_lim);
  assign is_last_bin  = (bin_q == last_bin);
  // Bin 0 loads unconditionally so stale results from a previous sweep never
  // survive; strict compare keeps the earlier bin on ties.
  assign take_result  = (bin_q == '0) || (res_max > best_max_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; res_valid on the limit cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          if (is_last_bin) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LAUNCH;
          end
        end else if (wait_expired) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: bin counter, wait counter, global peak, error flag
  always_comb begin
    bin_d         = bin_q;
    wait_cnt_d    = wait_cnt_q;
    best_max_d    = best_max_q;
    best_index_d  = best_index_q;
    best_freq_d   = best_freq_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d         = '0;
          timeout_err_d = 1'b0;
        end else begin
          bin_d         = bin_q;
        end
      end
      S_LAUNCH: begin
        wait_cnt_d = 32'd0;
      end
      S_WAIT: begin
        if (res_valid) begin
          if (take_result) begin
            best_max_d   = res_max;
            best_index_d = res_index;
            best_freq_d  = bin_q;
          end else begin
            best_max_d   = best_max_q;
          end
          if (is_last_bin) begin
            bin_d = bin_q;
          end else begin
            bin_d = bin_q + freq_bits'(1);
          end
        end else if (wait_expired) begin
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        bin_d = bin_q;
      end
      default: begin
        bin_d = bin_q;
      end
    endcase
  end

  // Output decode from the next state so every flag is registered in step
  // with the state it describes
  always_comb begin
    bin_start_d = 1'b0;
    res_ready_d = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      S_IDLE:   busy_d      = 1'b0;
      S_LAUNCH: bin_start_d = 1'b1;
      S_WAIT:   res_ready_d = 1'b1;
      S_DONE:   out_valid_d = 1'b1;
      default:  busy_d      = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q         <= '0;
      wait_cnt_q    <= 32'd0;
      best_max_q    <= '0;
      best_index_q  <= '0;
      best_freq_q   <= '0;
      timeout_err_q <= 1'b0;
      bin_start_q   <= 1'b0;
      res_ready_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      bin_q         <= bin_d;
      wait_cnt_q    <= wait_cnt_d;
      best_max_q    <= best_max_d;
      best_index_q  <= best_index_d;
      best_freq_q   <= best_freq_d;
      timeout_err_q <= timeout_err_d;
      bin_start_q   <= bin_start_d;
      res_ready_q   <= res_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign freq_bin    = bin_q;
  assign bin_start   = bin_start_q;
  assign res_ready   = res_ready_q;
  assign best_max    = best_max_q;
  assign best_index  = best_index_q;
  assign best_freq   = best_freq_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
